// File: rtl/decoder_scan_ctrl.sv
// Scan controller for the 4-to-16 one-hot decoder stage: walks the select
// index with a programmable dwell, in single, continuous or manual-step mode.
module decoder_scan_ctrl #(
   parameter int unsigned SEL_W   = 4,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               cont,
   input  logic               step_mode,
   input  logic               step,
   input  logic               load,
   input  logic [SEL_W-1:0]   load_sel,
   input  logic [DWELL_W-1:0] dwell,
   output logic [SEL_W-1:0]   sel,
   output logic               en,
   output logic               busy,
   output logic               sweep_done
);

   localparam logic [SEL_W-1:0] SEL_LAST = '1;

   typedef enum logic {IDLE, DRIVE} state_t;

   state_t             state, state_nx;
   logic [SEL_W-1:0]   sel_nx;
   logic               en_nx, busy_nx, done_nx;
   logic [DWELL_W-1:0] cnt, cnt_nx;
   logic [DWELL_W-1:0] dwell_q, dwell_nx;
   logic               cont_q, cont_nx;
   logic               step_q, step_nx;
   logic [DWELL_W-1:0] cnt_last;
   logic               advance;

   // A dwell of zero behaves like one cycle per index.
   assign cnt_last = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
   assign advance  = step_q ? step : (cnt == cnt_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         sel        <= '0;
         en         <= 1'b0;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
         cnt        <= '0;
         dwell_q    <= '0;
         cont_q     <= 1'b0;
         step_q     <= 1'b0;
      end else begin
         state      <= state_nx;
         sel        <= sel_nx;
         en         <= en_nx;
         busy       <= busy_nx;
         sweep_done <= done_nx;
         cnt        <= cnt_nx;
         dwell_q    <= dwell_nx;
         cont_q     <= cont_nx;
         step_q     <= step_nx;
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      en_nx    = 1'b0;
      busy_nx  = 1'b0;
      done_nx  = 1'b0;
      cnt_nx   = cnt;
      dwell_nx = dwell_q;
      cont_nx  = cont_q;
      step_nx  = step_q;

      case (state)
         IDLE: begin
            if (load)
               sel_nx = load_sel;
            // stop beats a coincident start
            if (start && !stop) begin
               state_nx = DRIVE;
               en_nx    = 1'b1;
               busy_nx  = 1'b1;
               cnt_nx   = '0;
               dwell_nx = dwell;
               cont_nx  = cont;
               step_nx  = step_mode;
            end
         end

         DRIVE: begin
            en_nx   = 1'b1;
            busy_nx = 1'b1;
            if (stop) begin
               state_nx = IDLE;
               en_nx    = 1'b0;
               busy_nx  = 1'b0;
               cnt_nx   = '0;
            end else if (advance) begin
               cnt_nx = '0;
               if (sel == SEL_LAST) begin
                  done_nx = 1'b1;
                  if (cont_q) begin
                     sel_nx = '0;
                  end else begin
                     state_nx = IDLE;
                     en_nx    = 1'b0;
                     busy_nx  = 1'b0;
                  end
               end else begin
                  sel_nx = sel + SEL_W'(1);
               end
            end else if (!step_q) begin
               cnt_nx = cnt + DWELL_W'(1);
            end
         end

         default: state_nx = IDLE;
      endcase
   end

endmodule
